// File: rtl/ldl_p2ram_fifo_ctrl_v1_if.sv
// ldl_p2ram_fifo_ctrl_v1_if
//   Bundles every non-clock/reset signal of the pseudo-two-port-RAM FIFO
//   controller so that the controller and its environment share one port.
//
//   Upstream stream   : s_valid, s_ready, s_data
//   Downstream stream : m_valid, m_ready, m_data
//   RAM write port    : ram_we, ram_wa, ram_din
//   RAM read port     : ram_re, ram_ra, ram_dout, ram_rv
//   Status            : count, full, empty, err
//
//   modport slave  : the FIFO controller's view
//   modport master : the surrounding logic's view (producer, consumer and RAM)
interface ldl_p2ram_fifo_ctrl_v1_if #(
    parameter int DW = 8,
    parameter int AW = 4,
    parameter int CW = 4
) ();
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;

    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;

    logic          ram_we;
    logic [AW-1:0] ram_wa;
    logic [DW-1:0] ram_din;
    logic          ram_re;
    logic [AW-1:0] ram_ra;
    logic [DW-1:0] ram_dout;
    logic          ram_rv;

    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          err;

    modport slave (
        input  s_valid, s_data, m_ready, ram_dout, ram_rv,
        output s_ready, m_valid, m_data,
        output ram_we, ram_wa, ram_din, ram_re, ram_ra,
        output count, full, empty, err
    );

    modport master (
        output s_valid, s_data, m_ready, ram_dout, ram_rv,
        input  s_ready, m_valid, m_data,
        input  ram_we, ram_wa, ram_din, ram_re, ram_ra,
        input  count, full, empty, err
    );
endinterface

// File: rtl/ldl_p2ram_fifo_ctrl_v1.sv
// ldl_p2ram_fifo_ctrl_v1
//   FIFO controller around an external pseudo-two-port RAM whose read data
//   returns registered, one cycle after the read request. A two-entry output
//   buffer absorbs that latency so the downstream side sees registered data
//   and the FIFO sustains one item per cycle.
//
//   Ports
//     clk    : single clock, rising edge
//     rst_n  : asynchronous active-low reset
//     bus    : ldl_p2ram_fifo_ctrl_v1_if.slave (streams, RAM ports, status)
//
//   Parameters
//     DW     : data width
//     DEPTH  : RAM entries (>= 2, any integer)
//     AW     : RAM address width
//     CW     : count width (holds DEPTH+2)
module ldl_p2ram_fifo_ctrl_v1 #(
    parameter int DW    = 8,
    parameter int DEPTH = 10,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH + 3)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    ldl_p2ram_fifo_ctrl_v1_if.slave       bus
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [AW-1:0] LAST_C  = AW'(DEPTH - 1);

    logic [AW-1:0] wptr_q,     wptr_d;
    logic [AW-1:0] rptr_q,     rptr_d;
    logic [CW-1:0] ram_cnt_q,  ram_cnt_d;
    logic          inflight_q, inflight_d;
    logic [DW-1:0] obuf_q [2];
    logic [DW-1:0] obuf_d [2];
    logic [1:0]    obuf_cnt_q, obuf_cnt_d;
    logic          err_q,      err_d;
    // Held low through reset and set on the first edge after release, so
    // s_ready stays low while rst_n is asserted without a combinational
    // path from rst_n to the outputs.
    logic          run_q;

    logic          s_ready_w;
    logic          m_valid_w;
    logic          push;
    logic          pop;
    logic          rd;
    logic          rv_ok;
    logic [2:0]    occ_nxt;
    logic [1:0]    keep_cnt;

    // ------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------
    assign s_ready_w = run_q && (ram_cnt_q != DEPTH_C);
    assign m_valid_w = (obuf_cnt_q != 2'd0);
    assign push      = bus.s_valid & s_ready_w;
    assign pop       = m_valid_w & bus.m_ready;

    // Output-buffer occupancy once this cycle's pop and the returning read
    // have settled; a new read is only launched if it will have a slot.
    assign occ_nxt = {1'b0, obuf_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign rd      = (ram_cnt_q != '0) && (occ_nxt < 3'd2);

    // Returned data without its valid is dropped and flagged.
    assign rv_ok   = inflight_q & bus.ram_rv;

    // ------------------------------------------------------------------
    // Next state: pointers and RAM occupancy
    // ------------------------------------------------------------------
    always_comb begin
        wptr_d = wptr_q;
        if (push) begin
            wptr_d = (wptr_q == LAST_C) ? '0 : wptr_q + AW'(1);
        end
    end

    always_comb begin
        rptr_d = rptr_q;
        if (rd) begin
            rptr_d = (rptr_q == LAST_C) ? '0 : rptr_q + AW'(1);
        end
    end

    always_comb begin
        ram_cnt_d = ram_cnt_q;
        case ({push, rd})
            2'b10:   ram_cnt_d = ram_cnt_q + CW'(1);
            2'b01:   ram_cnt_d = ram_cnt_q - CW'(1);
            default: ram_cnt_d = ram_cnt_q;
        endcase
    end

    assign inflight_d = rd;
    assign err_d      = err_q | (inflight_q & ~bus.ram_rv);

    // ------------------------------------------------------------------
    // Next state: output buffer
    // The head shifts out on pop first; returning RAM data then lands in
    // the first free slot, which keeps FIFO order in a pop+fill cycle.
    // ------------------------------------------------------------------
    always_comb begin
        obuf_d[0]  = obuf_q[0];
        obuf_d[1]  = obuf_q[1];
        keep_cnt   = obuf_cnt_q - {1'b0, pop};
        obuf_cnt_d = keep_cnt;
        if (pop) begin
            obuf_d[0] = obuf_q[1];
        end
        if (rv_ok) begin
            if (keep_cnt == 2'd0) begin
                obuf_d[0] = bus.ram_dout;
            end else begin
                obuf_d[1] = bus.ram_dout;
            end
            obuf_cnt_d = keep_cnt + 2'd1;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            ram_cnt_q  <= '0;
            inflight_q <= 1'b0;
            obuf_q[0]  <= '0;
            obuf_q[1]  <= '0;
            obuf_cnt_q <= 2'd0;
            err_q      <= 1'b0;
            run_q      <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            ram_cnt_q  <= ram_cnt_d;
            inflight_q <= inflight_d;
            obuf_q[0]  <= obuf_d[0];
            obuf_q[1]  <= obuf_d[1];
            obuf_cnt_q <= obuf_cnt_d;
            err_q      <= err_d;
            run_q      <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.s_ready = s_ready_w;
    assign bus.m_valid = m_valid_w;
    assign bus.m_data  = obuf_q[0];

    assign bus.ram_we  = push;
    assign bus.ram_wa  = wptr_q;
    assign bus.ram_din = bus.s_data;
    assign bus.ram_re  = rd;
    assign bus.ram_ra  = rptr_q;

    assign bus.count   = ram_cnt_q + CW'(inflight_q) + CW'(obuf_cnt_q);
    assign bus.empty   = (bus.count == '0);
    assign bus.full    = (ram_cnt_q == DEPTH_C);
    assign bus.err     = err_q;

endmodule

// File: tb/tb_ldl_p2ram_fifo_ctrl_v1.sv
module tb_ldl_p2ram_fifo_ctrl_v1;

    localparam int DW    = 8;
    localparam int DEPTH = 10;
    localparam int AW    = 4;
    localparam int CW    = 4;

    logic clk;
    logic rst_n;
    logic drop_rv;

    ldl_p2ram_fifo_ctrl_v1_if #(.DW(DW), .AW(AW), .CW(CW)) bus ();

    ldl_p2ram_fifo_ctrl_v1 #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .CW(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: registered read, valid one cycle after ram_re
    logic [DW-1:0] mem [DEPTH];
    initial begin
        bus.ram_dout = '0;
        bus.ram_rv   = 1'b0;
    end
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_wa] <= bus.ram_din;
        bus.ram_dout <= mem[bus.ram_ra];
        bus.ram_rv   <= bus.ram_re & ~drop_rv;
    end

    int nchk;
    int nfail;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        rst_n       = 1'b0;
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b0;
        drop_rv     = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    typedef struct {
        logic [7:0] din;
        logic       exp_rdy;
        logic [3:0] exp_cnt;
        logic       exp_mv;
    } vec_t;

    vec_t fill_v [15];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int pushed, popped, wraps, conf, first, last;
        logic [3:0] prev_wa;
        logic       seen;

        nchk  = 0;
        nfail = 0;

        // m_ready held low: items trickle into the output buffer, count
        // grows by one per accepted push, RAM saturates after 12 pushes.
        fill_v[0]  = '{8'h10, 1'b1, 4'd0,  1'b0};
        fill_v[1]  = '{8'h11, 1'b1, 4'd1,  1'b0};
        fill_v[2]  = '{8'h12, 1'b1, 4'd2,  1'b0};
        fill_v[3]  = '{8'h13, 1'b1, 4'd3,  1'b1};
        fill_v[4]  = '{8'h14, 1'b1, 4'd4,  1'b1};
        fill_v[5]  = '{8'h15, 1'b1, 4'd5,  1'b1};
        fill_v[6]  = '{8'h16, 1'b1, 4'd6,  1'b1};
        fill_v[7]  = '{8'h17, 1'b1, 4'd7,  1'b1};
        fill_v[8]  = '{8'h18, 1'b1, 4'd8,  1'b1};
        fill_v[9]  = '{8'h19, 1'b1, 4'd9,  1'b1};
        fill_v[10] = '{8'h1A, 1'b1, 4'd10, 1'b1};
        fill_v[11] = '{8'h1B, 1'b1, 4'd11, 1'b1};
        fill_v[12] = '{8'h1C, 1'b0, 4'd12, 1'b1};
        fill_v[13] = '{8'h1D, 1'b0, 4'd12, 1'b1};
        fill_v[14] = '{8'h1E, 1'b0, 4'd12, 1'b1};

        // ---- reset state ----
        rst_n       = 1'b0;
        drop_rv     = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_data  = 8'hFF;
        bus.m_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_s_ready", bus.s_ready, 0);
        chk("rst_m_valid", bus.m_valid, 0);
        chk("rst_count",   bus.count,   0);
        chk("rst_empty",   bus.empty,   1);
        chk("rst_full",    bus.full,    0);
        chk("rst_ram_we",  bus.ram_we,  0);
        chk("rst_ram_re",  bus.ram_re,  0);
        tick();
        rst_n       = 1'b1;
        bus.s_valid = 1'b0;
        tick();
        @(negedge clk);
        chk("rel_s_ready", bus.s_ready, 1);
        chk("rel_empty",   bus.empty,   1);
        chk("rel_count",   bus.count,   0);
        chk("rel_m_valid", bus.m_valid, 0);
        chk("rel_err",     bus.err,     0);

        // ---- single push latency ----
        tick();
        bus.s_valid = 1'b1;
        bus.s_data  = 8'hA5;
        bus.m_ready = 1'b1;
        @(negedge clk);
        chk("lat_ram_we", bus.ram_we, 1);
        tick();
        bus.s_valid = 1'b0;
        @(negedge clk);
        chk("lat_ram_re", bus.ram_re, 1);
        chk("lat_ram_ra", bus.ram_ra, 0);
        tick();
        tick();
        @(negedge clk);
        chk("lat_m_valid", bus.m_valid, 1);
        chk("lat_m_data",  bus.m_data,  8'hA5);
        tick();
        @(negedge clk);
        chk("lat_empty", bus.empty, 1);

        // ---- fill to full (table driven) ----
        do_reset();
        bus.m_ready = 1'b0;
        for (int i = 0; i < 15; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = fill_v[i].din;
            @(negedge clk);
            chk($sformatf("fill%0d_s_ready", i), bus.s_ready, fill_v[i].exp_rdy);
            chk($sformatf("fill%0d_count", i),   bus.count,   fill_v[i].exp_cnt);
            chk($sformatf("fill%0d_m_valid", i), bus.m_valid, fill_v[i].exp_mv);
            tick();
        end
        bus.s_valid = 1'b0;
        @(negedge clk);
        chk("full_full",    bus.full,    1);
        chk("full_s_ready", bus.s_ready, 0);
        chk("full_count",   bus.count,   12);
        chk("full_m_data",  bus.m_data,  8'h10);

        // ---- drain ----
        tick();
        bus.m_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 40 && n < 12; c++) begin
            @(negedge clk);
            if (bus.m_valid) begin
                chk($sformatf("drain%0d_data", n), bus.m_data, 8'h10 + n);
                n++;
            end
        end
        chk("drain_items", n, 12);
        @(negedge clk);
        chk("drain_empty", bus.empty, 1);

        // ---- continuous streaming of 25 items ----
        do_reset();
        bus.m_ready = 1'b1;
        pushed = 0; popped = 0; wraps = 0; conf = 0; first = -1; last = -1;
        prev_wa = '0; seen = 1'b0;
        for (int c = 0; c < 45; c++) begin
            bus.s_valid = (pushed < 25);
            bus.s_data  = pushed[7:0];
            @(negedge clk);
            if (bus.ram_we) begin
                if (seen && prev_wa == 4'd9 && bus.ram_wa == 4'd0) wraps++;
                prev_wa = bus.ram_wa;
                seen    = 1'b1;
                pushed++;
            end
            if (bus.ram_we && bus.ram_re && bus.ram_wa == bus.ram_ra) conf++;
            if (bus.m_valid) begin
                chk($sformatf("stream%0d_data", popped), bus.m_data, popped);
                if (first < 0) first = c;
                last = c;
                popped++;
            end
            tick();
        end
        bus.s_valid = 1'b0;
        chk("stream_popped",   popped, 25);
        chk("stream_backtoback", last - first, 24);
        chk("stream_wraps",    wraps, 2);
        chk("stream_conflict", conf, 0);

        // ---- missing read valid sets sticky err ----
        do_reset();
        bus.m_ready = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_data  = 8'h55;
        tick();
        bus.s_valid = 1'b0;
        drop_rv     = 1'b1;
        @(negedge clk);
        chk("err_ram_re", bus.ram_re, 1);
        tick();
        drop_rv = 1'b0;
        @(negedge clk);
        chk("err_before", bus.err, 0);
        tick();
        @(negedge clk);
        chk("err_set", bus.err, 1);
        repeat (5) tick();
        @(negedge clk);
        chk("err_sticky", bus.err, 1);
        do_reset();
        @(negedge clk);
        chk("err_cleared", bus.err, 0);

        // ---- asynchronous reset mid-operation ----
        tick();
        bus.m_ready = 1'b0;
        for (int k = 0; k < 7; k++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = 8'h40 + k[7:0];
            tick();
        end
        bus.s_valid = 1'b0;
        @(negedge clk);
        chk("mid_count_before", bus.count, 7);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_count_rst",   bus.count,   0);
        chk("mid_m_valid_rst", bus.m_valid, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        bus.s_valid = 1'b1;
        bus.s_data  = 8'h3C;
        tick();
        bus.s_valid = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk("mid_m_valid_new", bus.m_valid, 1);
        chk("mid_m_data_new",  bus.m_data,  8'h3C);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
